// File: rtl/ps2_move_decoder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_move_decoder_pkg : direction encodings, scan codes, key lookup  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ps2_move_decoder_pkg;

    localparam logic [2:0] DIR_STOP  = 3'b000;
    localparam logic [2:0] DIR_UP    = 3'b001;
    localparam logic [2:0] DIR_LEFT  = 3'b010;
    localparam logic [2:0] DIR_RIGHT = 3'b011;
    localparam logic [2:0] DIR_DOWN  = 3'b100;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_SPACE = 8'h29;

    typedef struct packed {
        logic       hit;
        logic [2:0] dir;
    } key_dir_t;

    // Arrow and WASD codes share a direction regardless of the E0 prefix.
    function automatic key_dir_t decode_dir(input logic [7:0] code);
        key_dir_t r;
        r.hit = 1'b1;
        r.dir = DIR_STOP;
        case (code)
            SC_UP,    SC_W: r.dir = DIR_UP;
            SC_LEFT,  SC_A: r.dir = DIR_LEFT;
            SC_RIGHT, SC_D: r.dir = DIR_RIGHT;
            SC_DOWN,  SC_S: r.dir = DIR_DOWN;
            default:        r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_move_decoder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_move_decoder_if : PS/2 pins in, movement state and byte out     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface ps2_move_decoder_if;
    logic       ps2c;
    logic       ps2d;
    logic [3:0] move_state;
    logic [7:0] out;

    modport master (output ps2c, output ps2d, input move_state, input out);
    modport slave  (input ps2c, input ps2d, output move_state, output out);
endinterface
`default_nettype wire

// File: rtl/ps2_move_decoder_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_rx : PS/2 sync, glitch filter, frame capture, check, timeout    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ps2_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       ps2c_i,
    input  wire logic       ps2d_i,
    output logic            byte_done_o,
    output logic [7:0]      data_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT = 4'd10;

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    assign w_raw = {ps2d_i, ps2c_i};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic          s1_q, s2_q, f_q;
        logic [FW-1:0] cnt_q;
        // A new level is accepted only after FILTER_LEN consecutive differing samples.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                f_q   <= 1'b1;
                cnt_q <= '0;
            end else begin
                s1_q <= w_raw[g];
                s2_q <= s1_q;
                if (s2_q != f_q) begin
                    if (cnt_q == FILT_MAX) begin
                        f_q   <= s2_q;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
        assign w_filt[g] = f_q;
    end

    logic          clk_prev_q;
    logic [3:0]    bitcnt_q;
    logic [9:0]    sr_q;
    logic [TW-1:0] to_q;
    logic          w_fall;
    logic [10:0]   w_frame;
    logic          w_valid;

    assign w_fall  = clk_prev_q & ~w_filt[0];
    assign w_frame = {w_filt[1], sr_q};
    assign w_valid = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    assign byte_done_o = w_fall && (bitcnt_q == LAST_BIT) && w_valid;
    assign data_o      = w_frame[8:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_q <= 1'b1;
            bitcnt_q   <= '0;
            sr_q       <= '0;
            to_q       <= '0;
        end else begin
            clk_prev_q <= w_filt[0];
            if (w_fall) begin
                to_q <= '0;
                // A high level where a start bit belongs leaves the receiver idle.
                if (bitcnt_q == LAST_BIT) begin
                    bitcnt_q <= '0;
                end else if (bitcnt_q != 4'd0 || !w_filt[1]) begin
                    sr_q     <= {w_filt[1], sr_q[9:1]};
                    bitcnt_q <= bitcnt_q + 1'b1;
                end
            end else if (bitcnt_q == 4'd0) begin
                to_q <= '0;
            end else if (to_q == TO_MAX) begin
                to_q     <= '0;
                bitcnt_q <= '0;
            end else begin
                to_q <= to_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_move_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_move_decoder : PS/2 make/break decode into {jump, dir[2:0]}     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module ps2_move_decoder
    import ps2_move_decoder_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ps2_move_decoder_if.slave  bus
);
    logic       w_byte_done;
    logic [7:0] w_data;
    key_dir_t   w_key;

    logic [7:0] out_q, out_d;
    logic [2:0] dir_q, dir_d;
    logic       jump_q, jump_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .ps2c_i      (bus.ps2c),
        .ps2d_i      (bus.ps2d),
        .byte_done_o (w_byte_done),
        .data_o      (w_data)
    );

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        jump_d = jump_q;
        ext_d  = ext_q;
        brk_d  = brk_q;
        w_key  = decode_dir(w_data);
        if (w_byte_done) begin
            out_d = w_data;
            if (w_data == SC_EXT) begin
                ext_d = 1'b1;
            end else if (w_data == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                // Releasing a key only stops motion if it is the one currently driving it.
                if (w_key.hit) begin
                    if (!brk_q)
                        dir_d = w_key.dir;
                    else if (dir_q == w_key.dir)
                        dir_d = DIR_STOP;
                end else if (w_data == SC_SPACE && !ext_q) begin
                    jump_d = ~brk_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= 8'h00;
            dir_q  <= DIR_STOP;
            jump_q <= 1'b0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            dir_q  <= dir_d;
            jump_q <= jump_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
        end
    end

    assign bus.move_state = {jump_q, dir_q};
    assign bus.out        = out_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_move_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ps2_move_decoder : table-driven bench for the PS/2 move decoder  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_ps2_move_decoder;
    localparam int HALF = 20;
    localparam int TMO  = 300;
    localparam int NV   = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    ps2_move_decoder_if bus ();

    ps2_move_decoder #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [3:0] exp_state;
        logic [7:0] exp_out;
    } vec_t;

    vec_t v [NV];

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = bad ? (^b) : ~(^b);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            bus.ps2d = f[i];
            wait_cyc(HALF);
            bus.ps2c = 1'b0;
            wait_cyc(HALF);
            bus.ps2c = 1'b1;
        end
        bus.ps2d = 1'b1;
        wait_cyc(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b0), 11);
    endtask

    task automatic check_both(input string name, input logic [3:0] st, input logic [7:0] o);
        check({name, ".state"}, {4'h0, bus.move_state}, {4'h0, st});
        check({name, ".out"}, bus.out, o);
    endtask

    initial begin
        v[0]  = '{8'hE0, 1'b0, 4'h0, 8'hE0};
        v[1]  = '{8'h75, 1'b0, 4'h1, 8'h75};
        v[2]  = '{8'hE0, 1'b0, 4'h1, 8'hE0};
        v[3]  = '{8'hF0, 1'b0, 4'h1, 8'hF0};
        v[4]  = '{8'h75, 1'b0, 4'h0, 8'h75};
        v[5]  = '{8'hE0, 1'b0, 4'h0, 8'hE0};
        v[6]  = '{8'h6B, 1'b0, 4'h2, 8'h6B};
        v[7]  = '{8'hE0, 1'b0, 4'h2, 8'hE0};
        v[8]  = '{8'h74, 1'b0, 4'h3, 8'h74};
        v[9]  = '{8'hE0, 1'b0, 4'h3, 8'hE0};
        v[10] = '{8'hF0, 1'b0, 4'h3, 8'hF0};
        v[11] = '{8'h6B, 1'b0, 4'h3, 8'h6B};
        v[12] = '{8'hE0, 1'b0, 4'h3, 8'hE0};
        v[13] = '{8'hF0, 1'b0, 4'h3, 8'hF0};
        v[14] = '{8'h74, 1'b0, 4'h0, 8'h74};
        v[15] = '{8'hE0, 1'b0, 4'h0, 8'hE0};
        v[16] = '{8'h75, 1'b0, 4'h1, 8'h75};
        v[17] = '{8'h29, 1'b0, 4'h9, 8'h29};
        v[18] = '{8'hF0, 1'b0, 4'h9, 8'hF0};
        v[19] = '{8'h29, 1'b0, 4'h1, 8'h29};
        v[20] = '{8'hE0, 1'b0, 4'h1, 8'hE0};
        v[21] = '{8'h29, 1'b0, 4'h1, 8'h29};
        v[22] = '{8'h75, 1'b1, 4'h1, 8'h29};
        v[23] = '{8'h1D, 1'b0, 4'h1, 8'h1D};

        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        rst = 1'b1;
        wait_cyc(2);
        check_both("reset", 4'h0, 8'h00);
        rst = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < NV; i++) begin
            send_bits(mk_frame(v[i].code, v[i].bad), 11);
            wait_cyc(4);
            check_both($sformatf("vec%0d", i), v[i].exp_state, v[i].exp_out);
        end

        // Partial frame abandoned by silence, then a clean left press.
        send_bits(mk_frame(8'h75, 1'b0), 5);
        wait_cyc(TMO + 50);
        send_byte(8'h1C);
        wait_cyc(4);
        check_both("timeout", 4'h2, 8'h1C);

        for (int k = 0; k < 3; k++) begin
            bus.ps2c = 1'b0;
            wait_cyc(2);
            bus.ps2c = 1'b1;
            wait_cyc(30);
        end
        send_byte(8'h23);
        wait_cyc(4);
        check_both("glitch", 4'h3, 8'h23);

        send_byte(8'h29);
        wait_cyc(4);
        check_both("space_dir", 4'hB, 8'h29);

        send_bits(mk_frame(8'h72, 1'b0), 4);
        rst = 1'b1;
        wait_cyc(2);
        check_both("midreset", 4'h0, 8'h00);
        rst = 1'b0;
        bus.ps2c = 1'b1;
        bus.ps2d = 1'b1;
        wait_cyc(TMO + 50);
        send_byte(8'h6B);
        wait_cyc(4);
        check_both("after_reset", 4'h2, 8'h6B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
